// File: rtl/uart_tx_word.sv
// uart_tx_word
//
// Multi-byte UART transmitter. A word of NBYTES bytes goes out as NBYTES
// back-to-back frames: one start bit, eight data bits sent LSB first, an
// optional parity bit, then STOP_BITS stop bits. There is no idle gap between
// the frames of one word. Bit timing comes from a baud counter on the system
// clock, so no derived clock is needed.
//
// Handshake (start / busy / tx_done):
//   - While idle, start high on a rising clk edge is accepted and data_in is
//     captured at that edge. busy is high from the next cycle until the word
//     is complete.
//   - tx_done pulses for one cycle, the first cycle back in idle, with busy
//     low. A start seen in that cycle is accepted, so a held start sends
//     words with a single idle-high cycle between them.
//   - A start while busy is dropped. It is not queued, and the captured word
//     is not affected.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset; aborts any frame at once
//   start      transmit request
//   data_in    word to send (8*NBYTES bits)
//   tx_out     serial line, idles high
//   busy       word in progress
//   tx_done    one-cycle completion pulse
//   byte_idx   transmit-order index of the byte on the line, 0 when idle
//   state_dbg  current FSM state (0 idle, 1 start, 2 data, 3 parity, 4 stop)

module uart_tx_word #(
    parameter int NBYTES       = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int MSB_FIRST    = 1,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          start,
    input  logic [8*NBYTES-1:0]                           data_in,
    output logic                                          tx_out,
    output logic                                          busy,
    output logic                                          tx_done,
    output logic [$clog2(NBYTES > 1 ? NBYTES : 2)-1:0]    byte_idx,
    output logic [2:0]                                    state_dbg
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES > 1 ? NBYTES : 2);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NBYTES - 1);
    localparam logic             PAR_EN    = (PARITY != 0);
    localparam logic             PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t           state;
    logic [W-1:0]     word_q;     // remaining bytes; the next one sits at the send end
    logic [7:0]       shift_q;    // current byte, shifted out LSB first
    logic             par_q;      // parity of the current byte, computed at load
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;    // data bit index in DATA, stop bit index in STOP
    logic             baud_wrap;
    logic [W-1:0]     next_word;

    assign state_dbg = state;
    assign baud_wrap = (baud_cnt == BAUD_LAST);

    // Drop the byte just sent so the next one moves to the send end.
    assign next_word = (MSB_FIRST != 0) ? (word_q << 8) : (word_q >> 8);

    function automatic logic [7:0] send_byte(input logic [W-1:0] w);
        if (MSB_FIRST != 0) begin
            return w[W-1 -: 8];
        end
        return w[7:0];
    endfunction

    function automatic logic parity_of(input logic [7:0] b);
        return (^b) ^ PAR_ODD;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            byte_idx <= '0;
            word_q   <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_out   <= 1'b1;
                    busy     <= 1'b0;
                    byte_idx <= '0;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (start) begin
                        word_q  <= data_in;
                        shift_q <= send_byte(data_in);
                        par_q   <= parity_of(send_byte(data_in));
                        state   <= S_START;
                        tx_out  <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                default: begin
                    // Every bit boundary falls on the counter wrap, so all
                    // bits last exactly CLKS_PER_BIT cycles.
                    baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
                    if (baud_wrap) begin
                        case (state)
                            S_START: begin
                                state   <= S_DATA;
                                tx_out  <= shift_q[0];
                                shift_q <= shift_q >> 1;
                                bit_cnt <= '0;
                            end
                            S_DATA: begin
                                if (bit_cnt == 3'd7) begin
                                    bit_cnt <= '0;
                                    if (PAR_EN) begin
                                        state  <= S_PAR;
                                        tx_out <= par_q;
                                    end else begin
                                        state  <= S_STOP;
                                        tx_out <= 1'b1;
                                    end
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                    tx_out  <= shift_q[0];
                                    shift_q <= shift_q >> 1;
                                end
                            end
                            S_PAR: begin
                                state   <= S_STOP;
                                tx_out  <= 1'b1;
                                bit_cnt <= '0;
                            end
                            S_STOP: begin
                                if (bit_cnt == STOP_LAST) begin
                                    bit_cnt <= '0;
                                    if (byte_idx == IDX_LAST) begin
                                        state    <= S_IDLE;
                                        busy     <= 1'b0;
                                        tx_done  <= 1'b1;
                                        tx_out   <= 1'b1;
                                        byte_idx <= '0;
                                    end else begin
                                        // Next byte starts straight away, no idle gap.
                                        state    <= S_START;
                                        tx_out   <= 1'b0;
                                        byte_idx <= byte_idx + 1'b1;
                                        word_q   <= next_word;
                                        shift_q  <= send_byte(next_word);
                                        par_q    <= parity_of(send_byte(next_word));
                                    end
                                end else begin
                                    bit_cnt <= bit_cnt + 1'b1;
                                end
                            end
                            default: begin
                                state  <= S_IDLE;
                                tx_out <= 1'b1;
                                busy   <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word. Four instances with different configurations share
// one clock and reset:
//   u0: NBYTES=4, MSB first, no parity, 1 stop
//   u1: NBYTES=4, LSB first, no parity, 1 stop
//   u2: NBYTES=1, even parity, 2 stop
//   u3: NBYTES=1, odd parity, 1 stop
// The reference model expands a word into the per-cycle line waveform
// {tx_done, byte_idx, busy, tx_out} from the framing rules.

module tb_uart_tx_word;

  localparam int CPB   = 4;
  localparam int OBS_W = 5;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_v [4];
  logic [31:0] data_v  [4];

  logic       tx_a, busy_a, done_a; logic [1:0] idx_a; logic [2:0] st_a;
  logic       tx_b, busy_b, done_b; logic [1:0] idx_b; logic [2:0] st_b;
  logic       tx_c, busy_c, done_c; logic       idx_c; logic [2:0] st_c;
  logic       tx_d, busy_d, done_d; logic       idx_d; logic [2:0] st_d;

  uart_tx_word #(.NBYTES(4), .CLKS_PER_BIT(CPB), .MSB_FIRST(1), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .data_in(data_v[0]),
    .tx_out(tx_a), .busy(busy_a), .tx_done(done_a), .byte_idx(idx_a), .state_dbg(st_a));
  uart_tx_word #(.NBYTES(4), .CLKS_PER_BIT(CPB), .MSB_FIRST(0), .PARITY(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .data_in(data_v[1]),
    .tx_out(tx_b), .busy(busy_b), .tx_done(done_b), .byte_idx(idx_b), .state_dbg(st_b));
  uart_tx_word #(.NBYTES(1), .CLKS_PER_BIT(CPB), .MSB_FIRST(1), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .data_in(data_v[2][7:0]),
    .tx_out(tx_c), .busy(busy_c), .tx_done(done_c), .byte_idx(idx_c), .state_dbg(st_c));
  uart_tx_word #(.NBYTES(1), .CLKS_PER_BIT(CPB), .MSB_FIRST(1), .PARITY(2), .STOP_BITS(1)) u3 (
    .clk(clk), .reset_n(reset_n), .start(start_v[3]), .data_in(data_v[3][7:0]),
    .tx_out(tx_d), .busy(busy_d), .tx_done(done_d), .byte_idx(idx_d), .state_dbg(st_d));

  // instance configuration table
  function automatic int p_n(input int u);    return (u < 2) ? 4 : 1; endfunction
  function automatic int p_msb(input int u);  return (u == 1) ? 0 : 1; endfunction
  function automatic int p_par(input int u);  return (u == 2) ? 1 : (u == 3) ? 2 : 0; endfunction
  function automatic int p_stop(input int u); return (u == 2) ? 2 : 1; endfunction

  function automatic logic [OBS_W-1:0] obs(input int u);
    case (u)
      0:       return {done_a, idx_a, busy_a, tx_a};
      1:       return {done_b, idx_b, busy_b, tx_b};
      2:       return {done_c, 1'b0, idx_c, busy_c, tx_c};
      default: return {done_d, 1'b0, idx_d, busy_d, tx_d};
    endcase
  endfunction

  // scoreboard
  logic [OBS_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: one word as a per-cycle waveform
  function automatic int frame_cycles(input int u);
    return (1 + 8 + ((p_par(u) != 0) ? 1 : 0) + p_stop(u)) * CPB;
  endfunction

  task automatic push_word(input int u, input logic [31:0] word);
    int n;
    int nbits;
    logic [7:0] b;
    logic par;
    logic bitv;
    n = p_n(u);
    nbits = frame_cycles(u) / CPB;
    for (int k = 0; k < n; k++) begin
      if (p_msb(u) != 0) b = word[8*(n-k)-1 -: 8];
      else               b = word[8*k +: 8];
      par = (^b) ^ (p_par(u) == 2);
      for (int j = 0; j < nbits; j++) begin
        if (j == 0)                          bitv = 1'b0;
        else if (j <= 8)                     bitv = b[j-1];
        else if (j == 9 && p_par(u) != 0)    bitv = par;
        else                                 bitv = 1'b1;
        for (int c = 0; c < CPB; c++) exp_q.push_back({1'b0, 2'(k), 1'b1, bitv});
      end
    end
    exp_q.push_back(5'b1_00_0_1);  // completion cycle
  endtask

  // driver: send a word (reps>1 holds start), optionally poke start mid-word
  // or pull reset at a given cycle
  task automatic run_word(input int u, input logic [31:0] word, input int reps,
                          input int poke_at, input int abort_at);
    int i;
    int busy_cnt;
    logic [OBS_W-1:0] got;
    logic [OBS_W-1:0] exp;
    exp_q.delete();
    for (int r = 0; r < reps; r++) push_word(u, word);
    exp_q.push_back(5'b0_00_0_1);  // back to idle, no further pulse
    start_v[u] = 1'b1;
    data_v[u]  = word;
    @(posedge clk);
    #1;
    if (reps == 1) begin
      start_v[u] = 1'b0;
      data_v[u]  = $urandom;  // must not disturb the captured word
    end
    i = 0;
    busy_cnt = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      got = obs(u);
      exp = exp_q.pop_front();
      check($sformatf("u%0d line c%0d", u, i), got, exp);
      if (got[1]) busy_cnt++;
      if (i == abort_at) begin
        reset_n = 1'b0;
        #1;
        check($sformatf("u%0d async_rst", u), obs(u), 5'b0_00_0_1);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check($sformatf("u%0d in_rst c%0d", u, k), obs(u), 5'b0_00_0_1);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check($sformatf("u%0d post_rst c%0d", u, k), obs(u), 5'b0_00_0_1);
        end
        exp_q.delete();
      end else if (i == poke_at) begin
        start_v[u] = 1'b1;
        data_v[u]  = ~word;
      end else if (reps == 1 || exp_q.size() == 1) begin
        start_v[u] = 1'b0;
      end
      i++;
    end
    start_v[u] = 1'b0;
    if (abort_at < 0)
      check($sformatf("u%0d busy_len", u), busy_cnt, reps * p_n(u) * frame_cycles(u));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 4; u++) begin
      start_v[u] = 1'b0;
      data_v[u]  = '0;
    end
    reset_n = 1'b0;
    #12;
    for (int u = 0; u < 4; u++) check($sformatf("u%0d reset", u), obs(u), 5'b0_00_0_1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++) check($sformatf("u%0d idle", u), obs(u), 5'b0_00_0_1);

    // MSB-first: A5 C3 0F 81, then random words
    run_word(0, 32'hA5C30F81, 1, -1, -1);
    for (int k = 0; k < 3; k++) run_word(0, $urandom, 1, -1, -1);
    // start while busy is ignored
    run_word(0, $urandom, 1, 10, -1);
    run_word(0, $urandom, 1, $urandom_range(20, 120), -1);
    // reset in the middle of byte 2, then a full word from byte 0
    run_word(0, 32'h3C96E11D, 1, -1, 90);
    run_word(0, 32'h3C96E11D, 1, -1, -1);

    // LSB-first: 81 0F C3 A5
    run_word(1, 32'hA5C30F81, 1, -1, -1);
    for (int k = 0; k < 2; k++) run_word(1, $urandom, 1, -1, -1);

    // even parity, two stop bits
    run_word(2, 32'h07, 1, -1, -1);
    run_word(2, $urandom, 2, -1, -1);
    for (int k = 0; k < 3; k++) run_word(2, $urandom, 1, -1, -1);

    // odd parity; held start repeats frames with one idle cycle between
    run_word(3, 32'h07, 1, -1, -1);
    run_word(3, 32'h55, 3, -1, -1);
    for (int k = 0; k < 3; k++) run_word(3, $urandom, 1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_word.md
Name: uart_tx_word

Overview:
- Parametrised multi-byte UART transmitter; successor to the fixed 16/32/128-bit serialisers.
- Serialises an NBYTES-wide word as NBYTES back-to-back 8N1-style frames, with configurable byte order, parity and stop bits.
- Runs entirely on the system clock, using an internal baud-tick counter instead of a derived tx clock.
- Sits between PUF response/control logic and the board TX pin. Uses a start/busy/done handshake.

Parameters:
- NBYTES, 4, number of bytes per word (>=1); data_in width is 8*NBYTES.
- CLKS_PER_BIT, 868, system clocks per serial bit (>=2); 868 gives 115200 baud at 100 MHz.
- MSB_FIRST, 1, 1 = send byte [8*NBYTES-1:8*NBYTES-8] first; 0 = send byte [7:0] first.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits per byte (1 or 2).

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, request transmission of data_in; sampled on rising clk.
- data_in, input, 8*NBYTES, word to send; captured only on an accepted start.
- tx_out, output, 1, serial line; idles high.
- busy, output, 1, high from the cycle after an accepted start until the word is complete.
- tx_done, output, 1, one-cycle pulse marking word completion.
- byte_idx, output, max(1,$clog2(NBYTES)), index (0-based, in transmit order) of the byte currently on the line; 0 when idle.

Behaviour:
- Reset (reset_n low, asynchronous):
  - tx_out=1, busy=0, tx_done=0, byte_idx=0.
  - state=IDLE; baud counter, bit counter and shift register all cleared.
  - Reset mid-frame aborts the frame immediately; no partial stop bit is sent.
  - After reset_n rises, the block stays IDLE until the next start.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE:
    - start=1 captures data_in into the word register.
    - Next cycle: state=START, tx_out=0, busy=1, byte_idx=0.
    - start=0 keeps tx_out=1.
  - START: held for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits of the current byte, LSB first, each held CLKS_PER_BIT cycles.
    - After bit 7: go to PAR if PARITY!=0, else STOP.
  - PAR: one bit.
    - Value = XOR of the 8 data bits for even parity; its inverse for odd.
  - STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - If bytes remain: byte_idx increments and state goes to START with no idle gap.
    - After the last byte: state=IDLE.
- Bit timing: the baud counter runs 0..CLKS_PER_BIT-1. Each bit changes tx_out exactly when the counter wraps; no jitter is allowed.
- Frame length:
  - One byte occupies (1+8+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
  - Latency from start accepted to busy falling = NBYTES*(1+8+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
- Completion cycle:
  - tx_done=1 for exactly the first cycle back in IDLE.
  - busy=0 in that same cycle.
- Byte selection:
  - MSB_FIRST=1: byte k on the line = data_in[8*(NBYTES-k)-1 -: 8].
  - MSB_FIRST=0: byte k on the line = data_in[8*k+7 -: 8].
- Handshake rules:
  - start while busy=1 is ignored; no queuing, and the captured word is unaffected.
  - start during the tx_done cycle is accepted, giving back-to-back words separated only by that one idle-high cycle.
  - Changes to data_in after capture have no effect.
- Edge cases:
  - NBYTES=1: byte_idx is 1 bit wide and stays 0.
  - A held start re-triggers on every tx_done cycle.

Test Plan:
- NBYTES=4, CLKS_PER_BIT=4, MSB_FIRST=1, no parity, 1 stop; start with data_in=32'hA5C30F81:
  - Line decodes bytes A5, C3, 0F, 81 in order, each bit held 4 cycles.
  - busy high for 160 cycles, then a single tx_done pulse.
- Same stimulus with MSB_FIRST=0:
  - Decodes 81, 0F, C3, A5.
  - byte_idx steps 0,1,2,3 at each START.
- PARITY=1, NBYTES=1, data 8'h07: parity bit = 1. PARITY=2, same data: parity bit = 0. STOP_BITS=2: line high for 8 cycles between frames.
- Pulse start at cycle 10 of a transmission with a different data_in:
  - Ignored; original word completes unchanged.
  - Only one tx_done pulse.
- Assert reset_n low in the middle of byte 2:
  - tx_out=1 and busy=0 asynchronously.
  - No tx_done.
  - A new start after release sends the full word from byte 0.
- NBYTES=1, start held high continuously with data 8'h55:
  - Frames repeat with exactly one idle cycle between them.
  - One tx_done per frame.
